multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32I datapath: instruction and data share one memory port.

---
 rtl/multicycle_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Shared definitions for the RV32I datapath.
package riscv_defs;
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } t_imm;
endpackage

// multicycle_ctrl
// Multi-cycle sequencer for an RV32I datapath with one shared memory port
// for instructions and data. A Moore FSM drives the PC/IR/regfile/ALU/memory
// enables from the opcode, the memory handshake and the debugger halt/step.
//
// State table:
//   IF   (0) | fetch instruction at PC, PC <= PC+4 on iMemReady
//   ID   (1) | decode, ALUOut <= oldPC+imm (branch/jump target)
//   EX   (2) | execute by opcode; branches and JAL finish here
//   MEM  (3) | data access at ALUOut, strobe held until iMemReady
//   WB   (4) | register write-back, JALR redirects PC
//   HALT (5) | parked by debugger at an instruction boundary
//   TRAP (6) | illegal opcode or bus timeout, held until reset
//
// Ports:
//   iCPU_Clk, iCPU_Reset      clock, synchronous active-low reset
//   iOpcode                   IR[6:0]
//   iMemReady                 memory handshake completion
//   iBranchCond               branch compare result, valid in EX
//   iDbgHalt, iDbgStep        debugger halt level / single-step pulse
//   oPCWrite, oPCSrc          PC load and source select
//   oIorD, oMemRD, oMemWR     memory address select and strobes
//   oIRWrite, oMDRWrite       instruction / load-data latches
//   oRegWrite, oWBSel         regfile write enable and source
//   oALUSrcA/B, oALUOp        ALU operand and operation selects
//   oImm_type                 immediate format for ImmGen
//   oFetch, oHalted, oTrap    boundary pulse, halt flag, sticky trap cause
//   oState                    current state code
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              iCPU_Clk,
  input  logic              iCPU_Reset,
  input  logic [6:0]        iOpcode,
  input  logic              iMemReady,
  input  logic              iBranchCond,
  input  logic              iDbgHalt,
  input  logic              iDbgStep,
  output logic              oPCWrite,
  output logic [1:0]        oPCSrc,
  output logic              oIorD,
  output logic              oMemRD,
  output logic              oMemWR,
  output logic              oIRWrite,
  output logic              oMDRWrite,
  output logic              oRegWrite,
  output logic [1:0]        oWBSel,
  output logic [1:0]        oALUSrcA,
  output logic [1:0]        oALUSrcB,
  output logic [1:0]        oALUOp,
  output riscv_defs::t_imm  oImm_type,
  output logic              oFetch,
  output logic              oHalted,
  output logic [1:0]        oTrap,
  output logic [3:0]        oState
);
  import riscv_defs::*;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX   = 4'd2,
    S_MEM  = 4'd3,
    S_WB   = 4'd4,
    S_HALT = 4'd5,
    S_TRAP = 4'd6
  } t_state;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Wait timer is a down-counter reloaded whenever no strobe is stalled;
  // terminal count 0 on a stalled cycle means MEM_TIMEOUT stalls have elapsed.
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_FULL = CW'(MEM_TIMEOUT - 1);

  t_state        state_q, state_nx;
  logic          run_q;
  logic          step_q, step_nx;
  logic [1:0]    trap_q, trap_nx;
  logic [CW-1:0] wait_q, wait_nx;
  logic          strobe;

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: is_legal = 1'b1;
      default:                                is_legal = 1'b0;
    endcase
  endfunction

  function automatic t_imm imm_of(input logic [6:0] opc);
    case (opc)
      OPC_OPIMM, OPC_LOAD, OPC_JALR: imm_of = IMM_I;
      OPC_STORE:                     imm_of = IMM_S;
      OPC_BRANCH:                    imm_of = IMM_B;
      OPC_LUI, OPC_AUIPC:            imm_of = IMM_U;
      OPC_JAL:                       imm_of = IMM_J;
      default:                       imm_of = IMM_NONE;
    endcase
  endfunction

  // run_q stays low while reset is held so every output reads 0 there,
  // even though the state register already sits at IF.
  always_ff @(posedge iCPU_Clk) begin
    if (!iCPU_Reset) begin
      state_q <= S_IF;
      run_q   <= 1'b0;
      step_q  <= 1'b0;
      trap_q  <= 2'b00;
      wait_q  <= WAIT_FULL;
    end else begin
      state_q <= state_nx;
      run_q   <= 1'b1;
      step_q  <= step_nx;
      trap_q  <= trap_nx;
      wait_q  <= wait_nx;
    end
  end

  always_comb begin
    state_nx  = state_q;
    step_nx   = step_q;
    trap_nx   = trap_q;
    wait_nx   = WAIT_FULL;
    strobe    = 1'b0;
    oPCWrite  = 1'b0;
    oPCSrc    = 2'b00;
    oIorD     = 1'b0;
    oMemRD    = 1'b0;
    oMemWR    = 1'b0;
    oIRWrite  = 1'b0;
    oMDRWrite = 1'b0;
    oRegWrite = 1'b0;
    oWBSel    = 2'b00;
    oALUSrcA  = 2'b00;
    oALUSrcB  = 2'b00;
    oALUOp    = 2'b00;
    oImm_type = IMM_NONE;
    oFetch    = 1'b0;
    oHalted   = 1'b0;
    oTrap     = trap_q;
    oState    = state_q;

    if (!run_q) begin
      state_nx = S_IF;
    end else begin
      if (state_q inside {S_ID, S_EX, S_MEM, S_WB})
        oImm_type = imm_of(iOpcode);

      case (state_q)
        S_IF: begin
          // Halt is only honoured before the strobe goes out; a fetch that is
          // already waiting on memory runs to completion.
          if (iDbgHalt && !step_q && (wait_q == WAIT_FULL)) begin
            state_nx = S_HALT;
          end else begin
            // The datapath steers PC into the ALU during fetch; B = 4.
            oMemRD   = 1'b1;
            oALUSrcB = 2'b10;
            if (iMemReady) begin
              oIRWrite = 1'b1;
              oPCWrite = 1'b1;
              oFetch   = 1'b1;
              step_nx  = 1'b0;
              state_nx = S_ID;
            end
          end
        end

        S_ID: begin
          oALUSrcA = 2'b01;
          oALUSrcB = 2'b01;
          if (is_legal(iOpcode)) begin
            state_nx = S_EX;
          end else begin
            state_nx = S_TRAP;
            trap_nx  = 2'b01;
          end
        end

        S_EX: begin
          case (iOpcode)
            OPC_OP: begin
              oALUOp   = 2'b10;
              state_nx = S_WB;
            end
            OPC_OPIMM: begin
              oALUSrcB = 2'b01;
              oALUOp   = 2'b10;
              state_nx = S_WB;
            end
            OPC_LUI: begin
              oALUSrcA = 2'b10;
              oALUSrcB = 2'b01;
              state_nx = S_WB;
            end
            OPC_AUIPC: begin
              oALUSrcA = 2'b01;
              oALUSrcB = 2'b01;
              state_nx = S_WB;
            end
            OPC_LOAD, OPC_STORE: begin
              oALUSrcB = 2'b01;
              state_nx = S_MEM;
            end
            OPC_BRANCH: begin
              // Target was parked in ALUOut during ID.
              oALUOp   = 2'b01;
              oPCSrc   = 2'b01;
              oPCWrite = iBranchCond;
              state_nx = S_IF;
            end
            OPC_JAL: begin
              oRegWrite = 1'b1;
              oWBSel    = 2'b10;
              oPCWrite  = 1'b1;
              oPCSrc    = 2'b01;
              state_nx  = S_IF;
            end
            OPC_JALR: begin
              oALUSrcB = 2'b01;
              state_nx = S_WB;
            end
            default: begin
              state_nx = S_TRAP;
              trap_nx  = 2'b01;
            end
          endcase
        end

        S_MEM: begin
          oIorD = 1'b1;
          if (iOpcode == OPC_LOAD) begin
            oMemRD = 1'b1;
            if (iMemReady) begin
              oMDRWrite = 1'b1;
              state_nx  = S_WB;
            end
          end else begin
            oMemWR = 1'b1;
            if (iMemReady)
              state_nx = S_IF;
          end
        end

        S_WB: begin
          oRegWrite = 1'b1;
          if (iOpcode == OPC_LOAD) begin
            oWBSel = 2'b01;
          end else if (iOpcode == OPC_JALR) begin
            oWBSel   = 2'b10;
            oPCWrite = 1'b1;
            oPCSrc   = 2'b10;
          end
          state_nx = S_IF;
        end

        S_HALT: begin
          oHalted = 1'b1;
          if (iDbgStep) begin
            step_nx  = 1'b1;
            state_nx = S_IF;
          end else if (!iDbgHalt) begin
            state_nx = S_IF;
          end
        end

        default: begin
          // TRAP: everything idle, cause held in trap_q.
        end
      endcase

      strobe = oMemRD | oMemWR;
      if (strobe && !iMemReady) begin
        if (wait_q == '0) begin
          state_nx = S_TRAP;
          trap_nx  = 2'b10;
        end else begin
          wait_nx = wait_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import riscv_defs::*;

  logic             clk;
  logic             rst_n;
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             br_cond;
  logic             dbg_halt;
  logic             dbg_step;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             iord;
  logic             mem_rd;
  logic             mem_wr;
  logic             ir_write;
  logic             mdr_write;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic [1:0]       src_a;
  logic [1:0]       src_b;
  logic [1:0]       alu_op;
  t_imm             imm_type;
  logic             fetch;
  logic             halted;
  logic [1:0]       trap;
  logic [3:0]       state;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .iCPU_Clk    (clk),
    .iCPU_Reset  (rst_n),
    .iOpcode     (opcode),
    .iMemReady   (mem_ready),
    .iBranchCond (br_cond),
    .iDbgHalt    (dbg_halt),
    .iDbgStep    (dbg_step),
    .oPCWrite    (pc_write),
    .oPCSrc      (pc_src),
    .oIorD       (iord),
    .oMemRD      (mem_rd),
    .oMemWR      (mem_wr),
    .oIRWrite    (ir_write),
    .oMDRWrite   (mdr_write),
    .oRegWrite   (reg_write),
    .oWBSel      (wb_sel),
    .oALUSrcA    (src_a),
    .oALUSrcB    (src_b),
    .oALUOp      (alu_op),
    .oImm_type   (imm_type),
    .oFetch      (fetch),
    .oHalted     (halted),
    .oTrap       (trap),
    .oState      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges, releases it and returns one edge later in IF.
  task automatic do_reset();
    rst_n = 1'b0;
    dbg_step = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 7'h00; mem_ready = 1'b0; br_cond = 1'b0;
    dbg_halt = 1'b0; dbg_step = 1'b0;
    tick();
    tick();
    #1;
    n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL rst_state: got %0d expected 0", state); end
    n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL rst_memrd: got %0b expected 0", mem_rd); end
    n_cmp++; if (src_b !== 2'b00) begin n_bad++; $display("FAIL rst_srcb: got %0b expected 00", src_b); end
    n_cmp++; if (trap !== 2'b00) begin n_bad++; $display("FAIL rst_trap: got %0b expected 00", trap); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %0b expected 0", halted); end
    rst_n = 1'b1;
    tick();
    #1;
    n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL rel_state: got %0d expected 0", state); end
    n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL rel_memrd: got %0b expected 1", mem_rd); end
    n_cmp++; if (src_b !== 2'b10) begin n_bad++; $display("FAIL rel_srcb: got %0b expected 10", src_b); end
  endtask

  task automatic test_addi();
    logic [3:0] st [5] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd0};
    logic       rw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       fe [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    opcode = 7'h13; mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (state !== st[c]) begin n_bad++; $display("FAIL addi_state[%0d]: got %0d expected %0d", c, state, st[c]); end
      n_cmp++; if (reg_write !== rw[c]) begin n_bad++; $display("FAIL addi_regwrite[%0d]: got %0b expected %0b", c, reg_write, rw[c]); end
      n_cmp++; if (fetch !== fe[c]) begin n_bad++; $display("FAIL addi_fetch[%0d]: got %0b expected %0b", c, fetch, fe[c]); end
      if (c == 1) begin
        n_cmp++; if (imm_type !== IMM_I) begin n_bad++; $display("FAIL addi_imm: got %0d expected %0d", imm_type, IMM_I); end
      end
      if (c == 2) begin
        n_cmp++; if ({src_a, src_b, alu_op} !== 6'b00_01_10) begin n_bad++; $display("FAIL addi_ex_alu: got %b expected 000110", {src_a, src_b, alu_op}); end
      end
      tick();
    end
  endtask

  task automatic test_load_waits();
    logic       rdy [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] st  [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       rd  [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int mdr_cnt = 0;
    do_reset();
    opcode = 7'h03;
    for (int c = 0; c < 10; c++) begin
      mem_ready = rdy[c];
      #1;
      n_cmp++; if (state !== st[c]) begin n_bad++; $display("FAIL lw_state[%0d]: got %0d expected %0d", c, state, st[c]); end
      n_cmp++; if (mem_rd !== rd[c]) begin n_bad++; $display("FAIL lw_memrd[%0d]: got %0b expected %0b", c, mem_rd, rd[c]); end
      if (c < 9 && mdr_write === 1'b1) mdr_cnt++;
      if (c == 6) begin
        n_cmp++; if (iord !== 1'b1) begin n_bad++; $display("FAIL lw_iord: got %0b expected 1", iord); end
      end
      if (c == 8) begin
        n_cmp++; if ({reg_write, wb_sel} !== 3'b101) begin n_bad++; $display("FAIL lw_wb: got %b expected 101", {reg_write, wb_sel}); end
      end
      tick();
    end
    n_cmp++; if (mdr_cnt !== 1) begin n_bad++; $display("FAIL lw_mdr_count: got %0d expected 1", mdr_cnt); end
  endtask

  task automatic test_branch();
    logic       bc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] st [7] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
    logic       pw [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    opcode = 7'h63; mem_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      br_cond = bc[c];
      #1;
      n_cmp++; if (state !== st[c]) begin n_bad++; $display("FAIL beq_state[%0d]: got %0d expected %0d", c, state, st[c]); end
      n_cmp++; if (pc_write !== pw[c]) begin n_bad++; $display("FAIL beq_pcwrite[%0d]: got %0b expected %0b", c, pc_write, pw[c]); end
      n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL beq_regwrite[%0d]: got %0b expected 0", c, reg_write); end
      if (c == 1) begin
        n_cmp++; if (imm_type !== IMM_B) begin n_bad++; $display("FAIL beq_imm: got %0d expected %0d", imm_type, IMM_B); end
        n_cmp++; if ({src_a, src_b} !== 4'b0101) begin n_bad++; $display("FAIL beq_id_target: got %b expected 0101", {src_a, src_b}); end
      end
      if (c == 2) begin
        n_cmp++; if ({pc_src, alu_op} !== 4'b0101) begin n_bad++; $display("FAIL beq_ex_sel: got %b expected 0101", {pc_src, alu_op}); end
      end
      tick();
    end
    br_cond = 1'b0;
  endtask

  task automatic test_jumps();
    logic [6:0] op [8] = '{7'h6F, 7'h6F, 7'h6F, 7'h67, 7'h67, 7'h67, 7'h67, 7'h67};
    logic [3:0] st [8] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd4, 4'd0};
    do_reset();
    mem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      opcode = op[c];
      #1;
      n_cmp++; if (state !== st[c]) begin n_bad++; $display("FAIL jump_state[%0d]: got %0d expected %0d", c, state, st[c]); end
      if (c == 2) begin
        n_cmp++; if ({reg_write, wb_sel, pc_write, pc_src} !== 6'b1_10_1_01) begin n_bad++; $display("FAIL jal_ex: got %b expected 110101", {reg_write, wb_sel, pc_write, pc_src}); end
      end
      if (c == 6) begin
        n_cmp++; if ({reg_write, wb_sel, pc_write, pc_src} !== 6'b1_10_1_10) begin n_bad++; $display("FAIL jalr_wb: got %b expected 110110", {reg_write, wb_sel, pc_write, pc_src}); end
      end
      tick();
    end
  endtask

  task automatic test_store_reset();
    logic       rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] st  [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    do_reset();
    opcode = 7'h23;
    for (int c = 0; c < 4; c++) begin
      mem_ready = rdy[c];
      #1;
      n_cmp++; if (state !== st[c]) begin n_bad++; $display("FAIL sw_state[%0d]: got %0d expected %0d", c, state, st[c]); end
      if (c == 3) begin
        n_cmp++; if ({mem_wr, mem_rd, iord} !== 3'b101) begin n_bad++; $display("FAIL sw_mem: got %b expected 101", {mem_wr, mem_rd, iord}); end
      end
      if (c < 3) tick();
    end
    rst_n = 1'b0;
    tick();
    #1;
    n_cmp++; if ({mem_wr, mem_rd, iord} !== 3'b000) begin n_bad++; $display("FAIL sw_abort_strobe: got %b expected 000", {mem_wr, mem_rd, iord}); end
    n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL sw_abort_state: got %0d expected 0", state); end
    rst_n = 1'b1;
    mem_ready = 1'b0;
    tick();
    #1;
    n_cmp++; if ({state, mem_rd, iord} !== 6'b0000_1_0) begin n_bad++; $display("FAIL sw_refetch: got %b expected 000010", {state, mem_rd, iord}); end
  endtask

  task automatic test_illegal();
    logic [3:0] st [6] = '{4'd0, 4'd1, 4'd6, 4'd6, 4'd6, 4'd6};
    logic [1:0] tr [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    do_reset();
    opcode = 7'h7F; mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++; if (state !== st[c]) begin n_bad++; $display("FAIL ill_state[%0d]: got %0d expected %0d", c, state, st[c]); end
      n_cmp++; if (trap !== tr[c]) begin n_bad++; $display("FAIL ill_trap[%0d]: got %b expected %b", c, trap, tr[c]); end
      if (c >= 2) begin
        n_cmp++; if ({mem_rd, pc_write, reg_write} !== 3'b000) begin n_bad++; $display("FAIL ill_idle[%0d]: got %b expected 000", c, {mem_rd, pc_write, reg_write}); end
      end
      tick();
    end
    opcode = 7'h13;
    do_reset();
    #1;
    n_cmp++; if ({state, trap} !== 6'b0000_00) begin n_bad++; $display("FAIL ill_cleared: got %b expected 000000", {state, trap}); end
  endtask

  task automatic test_timeout();
    logic       rdy [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] st  [5] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    do_reset();
    mem_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c < 4) begin
        n_cmp++; if ({state, mem_rd} !== 5'b0000_1) begin n_bad++; $display("FAIL to_wait[%0d]: got %b expected 00001", c, {state, mem_rd}); end
      end else begin
        n_cmp++; if ({state, trap, mem_rd} !== 7'b0110_10_0) begin n_bad++; $display("FAIL to_trap: got %b expected 0110100", {state, trap, mem_rd}); end
      end
      tick();
    end
    do_reset();
    opcode = 7'h13;
    for (int c = 0; c < 5; c++) begin
      mem_ready = rdy[c];
      #1;
      n_cmp++; if (state !== st[c]) begin n_bad++; $display("FAIL to_edge_state[%0d]: got %0d expected %0d", c, state, st[c]); end
      if (c == 3) begin
        n_cmp++; if (fetch !== 1'b1) begin n_bad++; $display("FAIL to_edge_fetch: got %0b expected 1", fetch); end
      end
      tick();
    end
    n_cmp++; if (trap !== 2'b00) begin n_bad++; $display("FAIL to_edge_trap: got %b expected 00", trap); end
  endtask

  task automatic test_halt_step();
    int fetch_cnt = 0;
    opcode = 7'h13; mem_ready = 1'b1; dbg_halt = 1'b1;
    do_reset();
    #1;
    n_cmp++; if ({state, mem_rd, fetch} !== 6'b0000_0_0) begin n_bad++; $display("FAIL halt_if: got %b expected 000000", {state, mem_rd, fetch}); end
    tick();
    #1;
    n_cmp++; if ({state, halted, mem_rd} !== 6'b0101_1_0) begin n_bad++; $display("FAIL halt_enter: got %b expected 010110", {state, halted, mem_rd}); end
    for (int k = 0; k < 3; k++) begin
      dbg_step = 1'b1;
      tick();
      dbg_step = 1'b0;
      for (int c = 0; c < 10; c++) begin
        #1;
        if (fetch === 1'b1) fetch_cnt++;
        if (state === 4'd5) break;
        tick();
      end
      n_cmp++; if ({state, halted} !== 5'b0101_1) begin n_bad++; $display("FAIL step_rehalt[%0d]: got %b expected 01011", k, {state, halted}); end
      tick();
    end
    n_cmp++; if (fetch_cnt !== 3) begin n_bad++; $display("FAIL step_fetches: got %0d expected 3", fetch_cnt); end
    dbg_halt = 1'b0;
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    #1;
    n_cmp++; if ({state, fetch} !== 5'b0000_1) begin n_bad++; $display("FAIL release_fetch: got %b expected 00001", {state, fetch}); end
    for (int c = 0; c < 4; c++) tick();
    #1;
    n_cmp++; if ({state, fetch, halted} !== 6'b0000_1_0) begin n_bad++; $display("FAIL release_run: got %b expected 000010", {state, fetch, halted}); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_waits();
    test_branch();
    test_jumps();
    test_store_reset();
    test_illegal();
    test_timeout();
    test_halt_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
